forwarding_bypass: RTL and testbench

//  Parametrised operand bypass network for the decode stage; successor to the single-producer forwarder.

---
 rtl/forwarding_bypass_pkg.sv | 27 ++
 rtl/forwarding_select.sv | 51 +++++
 rtl/forwarding_bypass.sv | 103 ++++++++++
 tb/tb_forwarding_bypass.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/forwarding_bypass_pkg.sv
// Shared types for the decode-stage operand bypass network.
// Struct data width follows FWD_XLEN; instantiate the top with XLEN equal to it.
package forwarding_bypass_pkg;

   localparam int unsigned FWD_XLEN = 32;
   localparam int unsigned FWD_AW   = 5;

   typedef struct packed {
      logic                valid;
      logic [FWD_AW-1:0]   waddr;
      logic [FWD_XLEN-1:0] wdata;
   } forwarding_hist_type;

   typedef struct packed {
      logic                wren;
      logic [FWD_AW-1:0]   waddr;
      logic                wvalid;
      logic [FWD_XLEN-1:0] wdata;
   } forwarding_src_type;

   // x0 is hardwired to zero and never acts as a producer.
   function automatic logic addr_match(input logic en, input logic [FWD_AW-1:0] src,
                                       input logic [FWD_AW-1:0] rd);
      return en && (src == rd) && (src != '0);
   endfunction

endpackage

// File: rtl/forwarding_select.sv
// One read port's priority mux: EX > MEM > history[0..N-1] > regfile, plus blocked flag.
import forwarding_bypass_pkg::*;

module forwarding_select #(
   parameter int unsigned HIST_DEPTH = 2
) (
   input  logic                                 rd_en,
   input  logic [FWD_AW-1:0]                    rd_addr,
   input  logic [FWD_XLEN-1:0]                  rf_rdata,
   input  logic                                 flush,
   input  forwarding_src_type                   ex_src,
   input  forwarding_src_type                   mem_src,
   input  forwarding_hist_type [HIST_DEPTH-1:0] hist,
   output logic [FWD_XLEN-1:0]                  data_out,
   output logic                                 fwd_hit,
   output logic                                 blocked
);

   logic found;

   always_comb begin
      data_out = '0;
      fwd_hit  = 1'b0;
      blocked  = 1'b0;
      found    = 1'b0;
      if (rd_en && (rd_addr != '0)) begin
         if (!flush && addr_match(ex_src.wren, ex_src.waddr, rd_addr)) begin
            data_out = ex_src.wdata;
            fwd_hit  = 1'b1;
            blocked  = !ex_src.wvalid;
         end else if (!flush && addr_match(mem_src.wren, mem_src.waddr, rd_addr)) begin
            data_out = mem_src.wdata;
            fwd_hit  = 1'b1;
            blocked  = !mem_src.wvalid;
         end else begin
            // History entries are always complete, so they never block.
            for (int h = 0; h < int'(HIST_DEPTH); h++) begin
               if (!found && addr_match(hist[h].valid, hist[h].waddr, rd_addr)) begin
                  data_out = hist[h].wdata;
                  fwd_hit  = 1'b1;
                  found    = 1'b1;
               end
            end
            if (!found) begin
               data_out = rf_rdata;
            end
         end
      end
   end

endmodule

// File: rtl/forwarding_bypass.sv
// Decode-stage operand bypass: NREAD ports fed from EX, MEM, WB history and regfile.
// Optional FORWARDING_PERF_EN adds stall and forward-count performance counters.
import forwarding_bypass_pkg::*;

module forwarding_bypass #(
   parameter int unsigned XLEN       = FWD_XLEN,
   parameter int unsigned NREAD      = 2,
   parameter int unsigned HIST_DEPTH = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREAD-1:0]        rd_en,
   input  logic [NREAD*5-1:0]      rd_addr,
   input  logic [NREAD*XLEN-1:0]   rf_rdata,
   input  logic                    ex_wren,
   input  logic [4:0]              ex_waddr,
   input  logic                    ex_wvalid,
   input  logic [XLEN-1:0]         ex_wdata,
   input  logic                    mem_wren,
   input  logic [4:0]              mem_waddr,
   input  logic                    mem_wvalid,
   input  logic [XLEN-1:0]         mem_wdata,
   input  logic                    wb_wren,
   input  logic [4:0]              wb_waddr,
   input  logic [XLEN-1:0]         wb_wdata,
   input  logic                    flush,
`ifdef FORWARDING_PERF_EN
   output logic [31:0]             perf_stall_cnt,
   output logic [31:0]             perf_fwd_cnt,
`endif
   output logic [NREAD*XLEN-1:0]   data_out,
   output logic [NREAD-1:0]        fwd_hit,
   output logic                    stall
);

   forwarding_src_type                   ex_src;
   forwarding_src_type                   mem_src;
   forwarding_hist_type                  hist_in;
   forwarding_hist_type [HIST_DEPTH-1:0] hist_q;
   logic [NREAD-1:0]                     blocked;

   always_comb begin
      ex_src  = '{wren: ex_wren,  waddr: ex_waddr,  wvalid: ex_wvalid,  wdata: ex_wdata};
      mem_src = '{wren: mem_wren, waddr: mem_waddr, wvalid: mem_wvalid, wdata: mem_wdata};
      hist_in = '0;
      if (wb_wren && (wb_waddr != '0)) begin
         hist_in = '{valid: 1'b1, waddr: wb_waddr, wdata: wb_wdata};
      end
   end

   // Index 0 is the newest commit; the oldest entry falls off the end.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
      end else begin
         hist_q[0] <= hist_in;
         for (int h = 1; h < int'(HIST_DEPTH); h++) begin
            hist_q[h] <= hist_q[h-1];
         end
      end
   end

   for (genvar i = 0; i < int'(NREAD); i++) begin : g_port
      forwarding_select #(
         .HIST_DEPTH (HIST_DEPTH)
      ) u_select (
         .rd_en    (rd_en[i]),
         .rd_addr  (rd_addr[5*i +: 5]),
         .rf_rdata (rf_rdata[XLEN*i +: XLEN]),
         .flush    (flush),
         .ex_src   (ex_src),
         .mem_src  (mem_src),
         .hist     (hist_q),
         .data_out (data_out[XLEN*i +: XLEN]),
         .fwd_hit  (fwd_hit[i]),
         .blocked  (blocked[i])
      );
   end

   assign stall = |blocked;

`ifdef FORWARDING_PERF_EN
   logic [31:0] fwd_inc;

   always_comb begin
      fwd_inc = '0;
      for (int i = 0; i < int'(NREAD); i++) begin
         fwd_inc = fwd_inc + {31'd0, fwd_hit[i] & ~stall};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_stall_cnt <= '0;
         perf_fwd_cnt   <= '0;
      end else begin
         perf_stall_cnt <= perf_stall_cnt + {31'd0, stall};
         perf_fwd_cnt   <= perf_fwd_cnt + fwd_inc;
      end
   end
`endif

endmodule

// File: tb/tb_forwarding_bypass.sv
// Directed bench for forwarding_bypass (NREAD=2, HIST_DEPTH=2); perf checks when FORWARDING_PERF_EN.
module tb_forwarding_bypass;

   localparam int XLEN = 32;
   localparam int NREAD = 2;
   localparam int HIST_DEPTH = 2;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [NREAD-1:0]      rd_en;
   logic [NREAD*5-1:0]    rd_addr;
   logic [NREAD*XLEN-1:0] rf_rdata;
   logic                  ex_wren, ex_wvalid, mem_wren, mem_wvalid, wb_wren, flush;
   logic [4:0]            ex_waddr, mem_waddr, wb_waddr;
   logic [XLEN-1:0]       ex_wdata, mem_wdata, wb_wdata;
   logic [NREAD*XLEN-1:0] data_out;
   logic [NREAD-1:0]      fwd_hit;
   logic                  stall;
`ifdef FORWARDING_PERF_EN
   logic [31:0]           perf_stall_cnt, perf_fwd_cnt;
`endif

   forwarding_bypass #(.XLEN(XLEN), .NREAD(NREAD), .HIST_DEPTH(HIST_DEPTH)) dut (
      .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rf_rdata(rf_rdata),
      .ex_wren(ex_wren), .ex_waddr(ex_waddr), .ex_wvalid(ex_wvalid), .ex_wdata(ex_wdata),
      .mem_wren(mem_wren), .mem_waddr(mem_waddr), .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata),
      .wb_wren(wb_wren), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush),
`ifdef FORWARDING_PERF_EN
      .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt),
`endif
      .data_out(data_out), .fwd_hit(fwd_hit), .stall(stall)
   );

   always #5 clock = ~clock;

   typedef struct {
      string                 tag;
      logic [NREAD*XLEN-1:0] data;
      logic [NREAD-1:0]      hit;
      logic                  stall;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic idle();
      rd_en = '0; rd_addr = '0; rf_rdata = '0; flush = 1'b0;
      ex_wren = 1'b0; ex_waddr = '0; ex_wvalid = 1'b0; ex_wdata = '0;
      mem_wren = 1'b0; mem_waddr = '0; mem_wvalid = 1'b0; mem_wdata = '0;
      wb_wren = 1'b0; wb_waddr = '0; wb_wdata = '0;
   endtask

   task automatic rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [31:0] rf0, input logic [31:0] rf1);
      rd_en = en; rd_addr = {a1, a0}; rf_rdata = {rf1, rf0};
   endtask

   task automatic ex(input logic [4:0] a, input logic v, input logic [31:0] d);
      ex_wren = 1'b1; ex_waddr = a; ex_wvalid = v; ex_wdata = d;
   endtask

   task automatic mem(input logic [4:0] a, input logic v, input logic [31:0] d);
      mem_wren = 1'b1; mem_waddr = a; mem_wvalid = v; mem_wdata = d;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      wb_wren = 1'b1; wb_waddr = a; wb_wdata = d;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [1:0] hit, input logic st);
      exp_t e;
      e.tag = tag; e.data = {d1, d0}; e.hit = hit; e.stall = st;
      sb.push_back(e);
   endtask

   // Compare at the falling edge, then advance to just after the next rising edge.
   task automatic check_step();
      exp_t e;
      @(negedge clock);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert (data_out === e.data) else begin
            errors++;
            $error("FAIL %s data_out observed=%h expected=%h", e.tag, data_out, e.data);
         end
         checks++;
         assert (fwd_hit === e.hit) else begin
            errors++;
            $error("FAIL %s fwd_hit observed=%b expected=%b", e.tag, fwd_hit, e.hit);
         end
         checks++;
         assert (stall === e.stall) else begin
            errors++;
            $error("FAIL %s stall observed=%b expected=%b", e.tag, stall, e.stall);
         end
      end
      @(posedge clock);
      #1;
      idle();
   endtask

   initial begin
      reset = 1'b0;
      idle();
      expect_out("reset", 32'h0, 32'h0, 2'b00, 1'b0);
      check_step();
`ifdef FORWARDING_PERF_EN
      checks++;
      assert (perf_stall_cnt === 32'd0 && perf_fwd_cnt === 32'd0) else begin
         errors++;
         $error("FAIL perf_reset observed=%0d/%0d expected=0/0", perf_stall_cnt, perf_fwd_cnt);
      end
`endif
      reset = 1'b1;

      // EX beats MEM
      rd(2'b01, 5'd5, 5'd0, 32'h1111, 32'h0);
      ex(5'd5, 1'b1, 32'hAAAA); mem(5'd5, 1'b1, 32'hBBBB);
      expect_out("ex_over_mem", 32'hAAAA, 32'h0, 2'b01, 1'b0);
      check_step();

      rd(2'b01, 5'd5, 5'd0, 32'h1111, 32'h0);
      mem(5'd5, 1'b1, 32'hBBBB);
      expect_out("mem_only", 32'hBBBB, 32'h0, 2'b01, 1'b0);
      check_step();

      // Load in EX: stall, no fall-through to the valid MEM value
      rd(2'b10, 5'd0, 5'd7, 32'h0, 32'h7777);
      ex(5'd7, 1'b0, 32'hDEAD); mem(5'd7, 1'b1, 32'h5555);
      expect_out("load_use", 32'h0, 32'hDEAD, 2'b10, 1'b1);
      check_step();

      rd(2'b10, 5'd0, 5'd7, 32'h0, 32'h7777);
      mem(5'd7, 1'b1, 32'h1234);
      expect_out("load_done", 32'h0, 32'h1234, 2'b10, 1'b0);
      check_step();

      // WB history window
      rd(2'b01, 5'd9, 5'd0, 32'h0BAD, 32'h0);
      wb(5'd9, 32'hCAFE);
      expect_out("wb_same_cycle", 32'h0BAD, 32'h0, 2'b00, 1'b0);
      check_step();
      rd(2'b01, 5'd9, 5'd0, 32'h0BAD, 32'h0);
      expect_out("hist_n1", 32'hCAFE, 32'h0, 2'b01, 1'b0);
      check_step();
      rd(2'b01, 5'd9, 5'd0, 32'h0BAD, 32'h0);
      expect_out("hist_n2", 32'hCAFE, 32'h0, 2'b01, 1'b0);
      check_step();
      rd(2'b01, 5'd9, 5'd0, 32'h0BAD, 32'h0);
      expect_out("hist_expired", 32'h0BAD, 32'h0, 2'b00, 1'b0);
      check_step();

      // Duplicate history entries: newest wins
      wb(5'd9, 32'h1);
      check_step();
      rd(2'b11, 5'd9, 5'd9, 32'h0BAD, 32'h0BAD);
      wb(5'd9, 32'h2);
      expect_out("dup_first", 32'h1, 32'h1, 2'b11, 1'b0);
      check_step();
      rd(2'b11, 5'd9, 5'd9, 32'h0BAD, 32'h0BAD);
      expect_out("dup_newest", 32'h2, 32'h2, 2'b11, 1'b0);
      check_step();

      // x0 never forwards and never enters history
      wb(5'd4, 32'h44);
      check_step();
      rd(2'b11, 5'd0, 5'd0, 32'h77, 32'h77);
      ex(5'd0, 1'b0, 32'hFFFF); mem(5'd0, 1'b0, 32'hFFFF); wb(5'd0, 32'hFFFF);
      expect_out("read_x0", 32'h0, 32'h0, 2'b00, 1'b0);
      check_step();
      rd(2'b11, 5'd4, 5'd0, 32'h77, 32'h77);
      expect_out("hist_after_x0", 32'h44, 32'h0, 2'b01, 1'b0);
      check_step();

      // Flush masks EX and MEM
      rd(2'b01, 5'd3, 5'd0, 32'h3030, 32'h0);
      ex(5'd3, 1'b0, 32'hEEEE); mem(5'd3, 1'b1, 32'h3333); flush = 1'b1;
      expect_out("flush", 32'h3030, 32'h0, 2'b00, 1'b0);
      check_step();

      // Disabled port ignores a blocking producer
      rd(2'b00, 5'd3, 5'd3, 32'h3030, 32'h3131);
      ex(5'd3, 1'b0, 32'hEEEE);
      expect_out("rd_en_off", 32'h0, 32'h0, 2'b00, 1'b0);
      check_step();

      // Mid-run reset clears history immediately
      wb(5'd11, 32'hB);
      check_step();
      rd(2'b11, 5'd11, 5'd0, 32'h11, 32'h0);
      wb(5'd12, 32'hC);
      expect_out("hist_filled", 32'hB, 32'h0, 2'b01, 1'b0);
      check_step();
      reset = 1'b0;
      rd(2'b11, 5'd12, 5'd11, 32'h12, 32'h11);
      expect_out("reset_midrun", 32'h12, 32'h11, 2'b00, 1'b0);
      check_step();
      reset = 1'b1;
      rd(2'b11, 5'd12, 5'd11, 32'h12, 32'h11);
      expect_out("after_reset", 32'h12, 32'h11, 2'b00, 1'b0);
      check_step();
`ifdef FORWARDING_PERF_EN
      checks++;
      assert (perf_stall_cnt === 32'd0 && perf_fwd_cnt === 32'd0) else begin
         errors++;
         $error("FAIL perf_cleared observed=%0d/%0d expected=0/0", perf_stall_cnt, perf_fwd_cnt);
      end
`endif

      // Three stall cycles
      for (int k = 0; k < 3; k++) begin
         rd(2'b10, 5'd0, 5'd7, 32'h0, 32'h7);
         ex(5'd7, 1'b0, 32'hD00D);
         expect_out("stall_run", 32'h0, 32'hD00D, 2'b10, 1'b1);
         check_step();
      end
      expect_out("idle_end", 32'h0, 32'h0, 2'b00, 1'b0);
      check_step();
`ifdef FORWARDING_PERF_EN
      checks++;
      assert (perf_stall_cnt === 32'd3 && perf_fwd_cnt === 32'd0) else begin
         errors++;
         $error("FAIL perf_stall3 observed=%0d/%0d expected=3/0", perf_stall_cnt, perf_fwd_cnt);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
